rotary_input_conditioner: RTL and testbench
===========================================

// Module: rotary_input_conditioner
// PURPOSE
//   Input stage for the rotary-shaft-encoder path. Synchronises the raw ROT_A/ROT_B
//   pins into clk, debounces each channel independently and delivers clean
//   quadrature levels plus 1-cycle change strobes.
//   Its outputs feed the encoder's ROT_A/ROT_B inputs directly.
//   A saturating counter of rejected glitches supports bring-up and debug.
// PARAMETERS
//   SYNC_STAGES    2     flip-flops per channel in the synchroniser chain; legal values >= 2
//   STABLE_CYCLES  16    consecutive differing samples required to accept a new level; legal values >= 2
//   IDLE_LEVEL     1'b0  reset value of the synchroniser flops and of the clean outputs
//   GLITCH_W       8     width of glitch_count
// PORTS
//   clk           in   1         system clock; all logic on the rising edge
//   rst           in   1         synchronous, active-high reset
//   rot_a_raw     in   1         asynchronous raw channel A from the pin
//   rot_b_raw     in   1         asynchronous raw channel B from the pin
//   rot_a         out  1         debounced channel A level
//   rot_b         out  1         debounced channel B level
//   rot_a_chg     out  1         1-cycle pulse in the same cycle that rot_a changes
//   rot_b_chg     out  1         1-cycle pulse in the same cycle that rot_b changes
//   glitch_count  out  GLITCH_W  saturating count of aborted pending transitions
// BEHAVIOUR
//   Reset (rst=1 at an edge):
//     - All synchroniser flops, rot_a and rot_b go to IDLE_LEVEL.
//     - rot_*_chg go to 0 and glitch_count goes to 0.
//     - Both channel FSMs go to STABLE with their counters at 0.
//   Reset mid-PENDING aborts the pending transition: no strobe, no glitch increment.
//   Per channel, s = last synchroniser stage, c = clean output register:
//   STABLE:
//     - If s==c, remain in STABLE.
//     - If s!=c, go to PENDING and set cnt<=1.
//   PENDING:
//     - If s==c, return to STABLE, cnt<=0 and count a glitch.
//     - Else if cnt==STABLE_CYCLES-1: c<=s, chg<=1, go to STABLE, cnt<=0.
//     - Otherwise cnt<=cnt+1.
//   chg is high for exactly one cycle; it is 0 in every cycle that has no commit.
//   Latency: number edge 1 as the first edge that samples the new raw level.
//     - s changes at edge SYNC_STAGES.
//     - rot_* and its chg strobe change at edge SYNC_STAGES+STABLE_CYCLES (18 with defaults).
//   Acceptance therefore needs STABLE_CYCLES consecutive samples of s that differ from c.
//   Any shorter excursion is rejected and counted as a glitch.
//   glitch_count:
//     - Adds 0, 1 or 2 per cycle; both channels may abort in the same cycle, giving +2.
//     - Saturates at 2^GLITCH_W-1 and never wraps.
//     - A +2 step from all-ones-minus-one saturates at all-ones.
//   Channel independence:
//     - The two channels are fully independent.
//     - Simultaneous commits on A and B are legal and both strobes assert in the same cycle.
//     - The block does no quadrature-legality checking; that belongs downstream.
//   cnt width is $clog2(STABLE_CYCLES); cnt never exceeds STABLE_CYCLES-1.
//   Raw toggling faster than STABLE_CYCLES produces no output change, only glitch counts.
// STRUCTURE
//   Shared header rotary_defs.vh holds:
//     - FSM encodings ST_STABLE=1'b0 and ST_PENDING=1'b1;
//     - default STABLE_CYCLES, reused by the encoder stages.
//   Sub-module quad_debounce_channel (instantiated twice, once for A and once for B):
//     - contains the synchroniser chain, the FSM, cnt and c;
//     - outputs level, chg and a 1-cycle abort pulse.
//   Top level: instantiates both channels and holds the saturating glitch counter,
//   which sums the two abort pulses.
// TESTING
//   1 Reset with IDLE_LEVEL=0 -> rot_a=rot_b=0, chg=0, glitch_count=0; unchanged over 40 idle cycles.
//   2 rot_a_raw 0->1, held -> rot_a=1 and rot_a_chg=1 exactly at edge 18; chg=0 at edges 17 and 19;
//     glitch_count=0.
//   3 rot_a_raw high for 10 cycles, then low -> rot_a stays 0, no strobe, glitch_count=1.
//   4 Both raw inputs rise on the same edge and are held -> rot_a_chg and rot_b_chg both pulse at edge 18.
//   5 With GLITCH_W=2: 5 short A pulses then 1 simultaneous short A+B pulse -> count 1,2,3 then stays 3.
//   6 rst asserted at edge 10 of a pending A rise, released, raw held high
//     -> no strobe during reset, count stays 0; rot_a rises 18 edges after release.

Source files
------------

// File: rtl/rotary_input_conditioner_pkg.sv
// Shared definitions for the rotary input conditioner: channel FSM encoding
// and default timing parameters reused by the downstream encoder stages.
package rotary_input_conditioner_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } chanState_e;

  localparam int DEFAULT_SYNC_STAGES   = 2;
  localparam int DEFAULT_STABLE_CYCLES = 16;
  localparam int DEFAULT_GLITCH_W      = 8;

endpackage

// File: rtl/rotary_input_conditioner_if.sv
// Pin-side bundle of the conditioner: raw quadrature inputs in, clean levels,
// change strobes and glitch counter out.
interface rotary_input_conditioner_if
  import rotary_input_conditioner_pkg::*;
#(
  parameter int GLITCH_W = DEFAULT_GLITCH_W
);

  logic                rot_a_raw;
  logic                rot_b_raw;
  logic                rot_a;
  logic                rot_b;
  logic                rot_a_chg;
  logic                rot_b_chg;
  logic [GLITCH_W-1:0] glitch_count;

  modport master (
    output rot_a_raw, rot_b_raw,
    input  rot_a, rot_b, rot_a_chg, rot_b_chg, glitch_count
  );

  modport slave (
    input  rot_a_raw, rot_b_raw,
    output rot_a, rot_b, rot_a_chg, rot_b_chg, glitch_count
  );

endinterface

// File: rtl/rotary_input_conditioner_channel.sv
// One debounced quadrature channel: synchroniser chain, STABLE/PENDING FSM,
// confirmation counter and clean level, plus 1-cycle change and abort pulses.
module rotary_input_conditioner_channel
  import rotary_input_conditioner_pkg::*;
#(
  parameter int   SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic IDLE_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic chg_o,
  output logic abort_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  chanState_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   chg_q;
  logic                   syncOut;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign syncOut = sync_q[SYNC_STAGES-1];

  // cnt counts consecutive samples that disagree with the committed level
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_q <= IDLE_LEVEL;
      chg_q   <= 1'b0;
    end else begin
      chg_q <= 1'b0;
      case (state_q)
        ST_STABLE: begin
          if (syncOut != level_q) begin
            state_q <= ST_PENDING;
            cnt_q   <= CNT_W'(1);
          end
        end
        ST_PENDING: begin
          if (syncOut == level_q) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            level_q <= syncOut;
            chg_q   <= 1'b1;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Abort is flagged in the cycle the FSM drops back, so the top-level counter
  // updates on the same edge; reset suppresses it.
  assign abort_o = !rst && (state_q == ST_PENDING) && (syncOut == level_q);
  assign level_o = level_q;
  assign chg_o   = chg_q;

endmodule

// File: rtl/rotary_input_conditioner.sv
// Rotary encoder input stage: two independent debounced channels and a
// saturating counter of rejected glitches across both.
module rotary_input_conditioner
  import rotary_input_conditioner_pkg::*;
#(
  parameter int   SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic IDLE_LEVEL    = 1'b0,
  parameter int   GLITCH_W      = DEFAULT_GLITCH_W
) (
  input logic                       clk,
  input logic                       rst,
  rotary_input_conditioner_if.slave bus
);

  localparam int SUM_W = GLITCH_W + 1;
  localparam logic [SUM_W-1:0] GLITCH_MAX = {1'b0, {GLITCH_W{1'b1}}};

  logic                levelA, levelB;
  logic                chgA, chgB;
  logic                abortA, abortB;
  logic [GLITCH_W-1:0] glitchCount_q;
  logic [GLITCH_W-1:0] glitchCount_d;
  logic [SUM_W-1:0]    glitchSum;

  rotary_input_conditioner_channel #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .IDLE_LEVEL   (IDLE_LEVEL)
  ) chanA (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (bus.rot_a_raw),
    .level_o(levelA),
    .chg_o  (chgA),
    .abort_o(abortA)
  );

  rotary_input_conditioner_channel #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .IDLE_LEVEL   (IDLE_LEVEL)
  ) chanB (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (bus.rot_b_raw),
    .level_o(levelB),
    .chg_o  (chgB),
    .abort_o(abortB)
  );

  // One extra bit of headroom lets a +2 step from max-1 clamp instead of wrapping
  always_comb begin
    glitchSum     = {1'b0, glitchCount_q} + SUM_W'(abortA) + SUM_W'(abortB);
    glitchCount_d = (glitchSum > GLITCH_MAX) ? {GLITCH_W{1'b1}} : glitchSum[GLITCH_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      glitchCount_q <= '0;
    end else begin
      glitchCount_q <= glitchCount_d;
    end
  end

  assign bus.rot_a        = levelA;
  assign bus.rot_b        = levelB;
  assign bus.rot_a_chg    = chgA;
  assign bus.rot_b_chg    = chgB;
  assign bus.glitch_count = glitchCount_q;

endmodule

// File: tb/tb_rotary_input_conditioner.sv
// Self-checking bench: a default instance and a GLITCH_W=2 instance share the
// same stimulus and are compared against a run-length reference model.
module tb_rotary_input_conditioner;

  localparam int SYNC   = 2;
  localparam int STABLE = 16;
  localparam int BIG_MAX   = 255;
  localparam int SMALL_MAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rotary_input_conditioner_if #(.GLITCH_W(8)) busBig ();
  rotary_input_conditioner_if #(.GLITCH_W(2)) busSmall ();

  rotary_input_conditioner #(.GLITCH_W(8)) dutBig (
    .clk(clk), .rst(rst), .bus(busBig)
  );

  rotary_input_conditioner #(.GLITCH_W(2)) dutSmall (
    .clk(clk), .rst(rst), .bus(busSmall)
  );

  always #5 clk = ~clk;

  // Reference: s is the raw input delayed SYNC edges; a level is accepted once
  // STABLE consecutive samples differ from it, any shorter run is a glitch.
  logic [1:0] mDelay [SYNC];
  logic [1:0] mLevel;
  logic [1:0] mChg;
  logic [1:0] mS;
  int         mRun [2];
  int         mAborts;
  int         mGlitchBig;
  int         mGlitchSmall;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC; i++) mDelay[i] = 2'b00;
      mLevel = 2'b00;
      mChg = 2'b00;
      mRun[0] = 0;
      mRun[1] = 0;
      mGlitchBig = 0;
      mGlitchSmall = 0;
    end else begin
      mS = mDelay[SYNC-1];
      mChg = 2'b00;
      mAborts = 0;
      for (int ch = 0; ch < 2; ch++) begin
        if (mS[ch] != mLevel[ch]) begin
          mRun[ch] = mRun[ch] + 1;
          if (mRun[ch] == STABLE) begin
            mLevel[ch] = mS[ch];
            mChg[ch] = 1'b1;
            mRun[ch] = 0;
          end
        end else begin
          if (mRun[ch] > 0) mAborts = mAborts + 1;
          mRun[ch] = 0;
        end
      end
      mGlitchBig = (mGlitchBig + mAborts > BIG_MAX) ? BIG_MAX : mGlitchBig + mAborts;
      mGlitchSmall = (mGlitchSmall + mAborts > SMALL_MAX) ? SMALL_MAX : mGlitchSmall + mAborts;
      for (int i = SYNC - 1; i > 0; i--) mDelay[i] = mDelay[i-1];
      mDelay[0] = {busBig.rot_b_raw, busBig.rot_a_raw};
    end
  end

  typedef struct {
    string name;
    int    lenA;
    int    lenB;
    logic  expA;
    logic  expB;
    int    expGlitch;
  } vec_t;

  localparam int HELD = 999;
  vec_t vecs [8];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setRaw(input logic a, input logic b);
    busBig.rot_a_raw   = a;
    busBig.rot_b_raw   = b;
    busSmall.rot_a_raw = a;
    busSmall.rot_b_raw = b;
  endtask

  task automatic doReset();
    setRaw(1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) stepCycle();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int total;
    total = ((v.lenA > v.lenB) ? v.lenA : v.lenB);
    if (total > 100) total = 0;
    doReset();
    for (int c = 0; c < total + 50; c++) begin
      setRaw((v.lenA == HELD) || (c < v.lenA), (v.lenB == HELD) || (c < v.lenB));
      stepCycle();
    end
    checkOutput({v.name, "_rot_a"}, int'(busBig.rot_a), int'(v.expA));
    checkOutput({v.name, "_rot_b"}, int'(busBig.rot_b), int'(v.expB));
    checkOutput({v.name, "_glitch"}, int'(busBig.glitch_count), v.expGlitch);
    checkOutput({v.name, "_glitch_small"}, int'(busSmall.glitch_count),
                (v.expGlitch > SMALL_MAX) ? SMALL_MAX : v.expGlitch);
  endtask

  task automatic shortPulse(input logic a, input logic b);
    setRaw(a, b);
    repeat (3) stepCycle();
    setRaw(1'b0, 1'b0);
    repeat (12) stepCycle();
  endtask

  initial begin
    vecs[0] = '{"idle",        0,    0,    1'b0, 1'b0, 0};
    vecs[1] = '{"a_glitch10",  10,   0,    1'b0, 1'b0, 1};
    vecs[2] = '{"a_glitch15",  15,   0,    1'b0, 1'b0, 1};
    vecs[3] = '{"a_pulse16",   16,   0,    1'b0, 1'b0, 0};
    vecs[4] = '{"b_glitch1",   0,    1,    1'b0, 1'b0, 1};
    vecs[5] = '{"both_glitch", 5,    5,    1'b0, 1'b0, 2};
    vecs[6] = '{"both_held",   HELD, HELD, 1'b1, 1'b1, 0};
    vecs[7] = '{"a_held_bgl",  HELD, 3,    1'b1, 1'b0, 1};

    // Reset state, held across idle cycles
    doReset();
    for (int c = 1; c <= 40; c++) begin
      stepCycle();
      if (c % 10 == 0) begin
        checkOutput("idle_rot_a", int'(busBig.rot_a), 0);
        checkOutput("idle_rot_b", int'(busBig.rot_b), 0);
        checkOutput("idle_chg", int'({busBig.rot_a_chg, busBig.rot_b_chg}), 0);
        checkOutput("idle_glitch", int'(busBig.glitch_count), 0);
      end
    end

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Exact acceptance edge for a held A rise
    doReset();
    setRaw(1'b1, 1'b0);
    for (int e = 1; e <= 19; e++) begin
      stepCycle();
      if (e == 17) begin
        checkOutput("lat_e17_rot_a", int'(busBig.rot_a), 0);
        checkOutput("lat_e17_chg", int'(busBig.rot_a_chg), 0);
      end else if (e == 18) begin
        checkOutput("lat_e18_rot_a", int'(busBig.rot_a), 1);
        checkOutput("lat_e18_chg", int'(busBig.rot_a_chg), 1);
      end else if (e == 19) begin
        checkOutput("lat_e19_rot_a", int'(busBig.rot_a), 1);
        checkOutput("lat_e19_chg", int'(busBig.rot_a_chg), 0);
      end
    end
    checkOutput("lat_glitch", int'(busBig.glitch_count), 0);

    // Simultaneous commits on both channels
    doReset();
    setRaw(1'b1, 1'b1);
    for (int e = 1; e <= 18; e++) begin
      stepCycle();
      if (e == 17) checkOutput("both_e17_chg", int'({busBig.rot_a_chg, busBig.rot_b_chg}), 0);
      if (e == 18) checkOutput("both_e18_chg", int'({busBig.rot_a_chg, busBig.rot_b_chg}), 3);
    end

    // Narrow counter saturation, including a +2 step at the top
    doReset();
    for (int p = 1; p <= 5; p++) begin
      shortPulse(1'b1, 1'b0);
      checkOutput("sat_small_count", int'(busSmall.glitch_count), (p > 3) ? 3 : p);
    end
    shortPulse(1'b1, 1'b1);
    checkOutput("sat_small_final", int'(busSmall.glitch_count), 3);
    checkOutput("sat_big_final", int'(busBig.glitch_count), 7);

    // Reset in the middle of a pending rise
    doReset();
    setRaw(1'b1, 1'b0);
    repeat (9) stepCycle();
    rst = 1'b1;
    for (int e = 0; e < 2; e++) begin
      stepCycle();
      checkOutput("rstmid_chg", int'(busBig.rot_a_chg), 0);
      checkOutput("rstmid_glitch", int'(busBig.glitch_count), 0);
    end
    rst = 1'b0;
    for (int e = 1; e <= 18; e++) begin
      stepCycle();
      if (e == 17) checkOutput("rstmid_e17_rot_a", int'(busBig.rot_a), 0);
      if (e == 18) begin
        checkOutput("rstmid_e18_rot_a", int'(busBig.rot_a), 1);
        checkOutput("rstmid_e18_chg", int'(busBig.rot_a_chg), 1);
      end
    end
    checkOutput("rstmid_glitch_end", int'(busBig.glitch_count), 0);

    // Randomised hold lengths against the reference model
    doReset();
    begin
      int   holdA, holdB;
      logic rawA, rawB;
      holdA = 0;
      holdB = 0;
      rawA = 1'b0;
      rawB = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (holdA == 0) begin
          rawA = 1'($urandom_range(0, 1));
          holdA = ($urandom_range(0, 3) == 0) ? $urandom_range(16, 30) : $urandom_range(1, 20);
        end
        if (holdB == 0) begin
          rawB = 1'($urandom_range(0, 1));
          holdB = ($urandom_range(0, 3) == 0) ? $urandom_range(16, 30) : $urandom_range(1, 20);
        end
        rst = (cyc >= 1500 && cyc < 1502);
        setRaw(rawA, rawB);
        stepCycle();
        holdA--;
        holdB--;
        checkOutput("rnd_rot_a", int'(busBig.rot_a), int'(mLevel[0]));
        checkOutput("rnd_rot_b", int'(busBig.rot_b), int'(mLevel[1]));
        checkOutput("rnd_chg_a", int'(busBig.rot_a_chg), int'(mChg[0]));
        checkOutput("rnd_chg_b", int'(busBig.rot_b_chg), int'(mChg[1]));
        checkOutput("rnd_glitch", int'(busBig.glitch_count), mGlitchBig);
        checkOutput("rnd_glitch_small", int'(busSmall.glitch_count), mGlitchSmall);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
